// File: rtl/stack_pkg.sv
// stack_pkg: shared helpers and error-mode constants for the stack controller
package stack_pkg;
  localparam int ERR_STICKY = 0;
  localparam int ERR_DYNAMIC = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/stack_ctl_sp.sv
// stack_ctl_sp: LIFO controller driving a single-port flop RAM with occupancy and status flags
module stack_ctl_sp
  import stack_pkg::*;
#(
  parameter int depth = 8,
  parameter int ae_level = 1,
  parameter int af_level = 1,
  parameter int err_mode = ERR_STICKY,
  localparam int AW = clog2(depth)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req_n,
  input  logic          pop_req_n,
  output logic          ram_cs_n,
  output logic          ram_wr_n,
  output logic [AW-1:0] rw_addr,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          almost_empty,
  output logic          almost_full,
  output logic          full,
  output logic          error
);
  if (depth < 2 || depth > 256) begin : g_bad_depth
    $error("stack_ctl_sp: depth out of range");
  end
  if (ae_level < 1 || ae_level > depth - 1) begin : g_bad_ae
    $error("stack_ctl_sp: ae_level out of range");
  end
  if (af_level < 1 || af_level > depth - 1) begin : g_bad_af
    $error("stack_ctl_sp: af_level out of range");
  end
  if (err_mode != ERR_STICKY && err_mode != ERR_DYNAMIC) begin : g_bad_err
    $error("stack_ctl_sp: err_mode out of range");
  end
  localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);
  localparam logic [AW:0] AE_CNT = (AW+1)'(ae_level);
  localparam logic [AW:0] AF_CNT = (AW+1)'(depth - af_level);
  logic [AW:0] cnt, cnt_m1;
  logic push, pop, is_empty, is_full, bad, do_push, do_pop;
  always_comb begin
    push = !push_req_n;
    pop = !pop_req_n;
    is_empty = cnt == '0;
    is_full = cnt == FULL_CNT;
    cnt_m1 = cnt - 1'b1;
    bad = (push && pop) || (push && is_full) || (pop && is_empty);
    do_push = push && !pop && !is_full;
    do_pop = pop && !push && !is_empty;
    ram_cs_n = !do_push && is_empty;
    // the write strobe is masked during reset so a push in that cycle never lands
    ram_wr_n = !(do_push && rst_n);
    rw_addr = do_push ? cnt[AW-1:0] : is_empty ? '0 : cnt_m1[AW-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      error <= 1'b0;
    end else begin
      cnt <= do_push ? cnt + 1'b1 : do_pop ? cnt_m1 : cnt;
      error <= (err_mode == ERR_DYNAMIC) ? bad : (error || bad);
    end
  end
  assign count = cnt;
  assign empty = cnt == '0;
  assign almost_empty = cnt <= AE_CNT;
  assign almost_full = cnt >= AF_CNT;
  assign full = cnt == FULL_CNT;
endmodule

// File: tb/tb_stack_ctl_sp.sv
// tb_stack_ctl_sp: directed and random traffic against a queue-based stack model, both error modes
module tb_stack_ctl_sp;
  logic clk, rst_n, push_req_n, pop_req_n;
  logic [7:0] din, dout;
  logic cs0, wr0, e0, ae0, af0, f0, err0;
  logic cs1, wr1, e1, ae1, af1, f1, err1;
  logic [2:0] addr0, addr1;
  logic [3:0] cnt0, cnt1;
  logic [7:0] mem [8];
  logic [7:0] stk [$];
  logic m_err0, m_err1;
  int checks, fails;

  stack_ctl_sp #(.depth(8), .ae_level(1), .af_level(1), .err_mode(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .ram_cs_n(cs0), .ram_wr_n(wr0), .rw_addr(addr0), .count(cnt0), .empty(e0),
    .almost_empty(ae0), .almost_full(af0), .full(f0), .error(err0));
  stack_ctl_sp #(.depth(8), .ae_level(1), .af_level(1), .err_mode(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .ram_cs_n(cs1), .ram_wr_n(wr1), .rw_addr(addr1), .count(cnt1), .empty(e1),
    .almost_empty(ae1), .almost_full(af1), .full(f1), .error(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!cs0 && !wr0) mem[addr0] <= din;
  assign dout = mem[addr0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic pu, input logic po, input logic rs, input logic [7:0] d);
    int n;
    logic lp, lo, bad;
    @(negedge clk);
    push_req_n = !pu;
    pop_req_n = !po;
    rst_n = rs;
    din = d;
    #1;
    n = stk.size();
    lp = pu && !po && n < 8;
    lo = po && !pu && n > 0;
    bad = (pu && po) || (pu && n == 8) || (po && n == 0);
    chk("ram_cs_n", cs0, !(lp || n > 0));
    chk("ram_wr_n", wr0, !(lp && rs));
    chk("rw_addr", addr0, lp ? n : (n > 0 ? n - 1 : 0));
    chk("ctl_match", {cs1, wr1, addr1}, {cs0, wr0, addr0});
    if (n > 0 && !lp) chk("data_out", dout, stk[n-1]);
    @(posedge clk);
    if (!rs) begin
      stk.delete();
      m_err0 = 1'b0;
      m_err1 = 1'b0;
    end else begin
      if (lp) stk.push_back(d);
      if (lo) void'(stk.pop_back());
      m_err0 = m_err0 || bad;
      m_err1 = bad;
    end
    #1;
    n = stk.size();
    chk("count", cnt0, n);
    chk("count_m1", cnt1, n);
    chk("flags", {e0, ae0, af0, f0}, {n == 0, n <= 1, n >= 7, n == 8});
    chk("error_sticky", err0, m_err0);
    chk("error_dynamic", err1, m_err1);
  endtask

  initial begin
    checks = 0;
    fails = 0;
    m_err0 = 1'b0;
    m_err1 = 1'b0;
    rst_n = 1'b0;
    push_req_n = 1'b1;
    pop_req_n = 1'b1;
    din = 8'h00;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 8'h20 + 8'(i));
    step(1, 0, 1, 8'hEE);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(1, 1, 1, 8'h55);
    step(0, 0, 1, 0);
    step(1, 0, 1, 8'hA1);
    step(1, 0, 1, 8'hA2);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 8'hA3);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 8'h66);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h30 + 8'(i));
    step(1, 0, 0, 8'hBB);
    step(0, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) != 0, 8'($urandom_range(0, 255)));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/stack_ctl_sp.md
# stack_ctl_sp

Synchronous LIFO (stack) controller that drives a flip-flop-based single-port RAM (DW_ram_rw_s_dff) directly upstream. It turns active-low push/pop requests into the RAM's `cs_n`, `wr_n` and `rw_addr`, and keeps a registered occupancy count. It also produces empty, almost-empty, almost-full, full and error status. Push data goes straight to the RAM's `data_in`, and popped data is the RAM's asynchronous `data_out`; neither passes through this block.

## Interface
- `depth`, default 8: stack depth in words. Legal range 2..256.
- `ae_level`, default 1: almost_empty is asserted when `count <= ae_level`. Legal range 1..depth-1.
- `af_level`, default 1: almost_full is asserted when `count >= depth - af_level`. Legal range 1..depth-1.
- `err_mode`, default 0: 0 = error is sticky until reset; 1 = error reflects only the previous cycle's request.
- `AW` (localparam) = ceil(log2(depth)).

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset. **Synchronous, active-low.**
- `push_req_n`, input, 1: push request, active low.
- `pop_req_n`, input, 1: pop request, active low.
- `ram_cs_n`, output, 1: RAM chip select, active low.
- `ram_wr_n`, output, 1: RAM write enable, active low.
- `rw_addr`, output, AW: RAM address.
- `count`, output, AW+1: current occupancy, 0..depth.
- `empty`, output, 1: `count == 0`.
- `almost_empty`, output, 1: `count <= ae_level`.
- `almost_full`, output, 1: `count >= depth - af_level`.
- `full`, output, 1: `count == depth`.
- `error`, output, 1: illegal request flag.

## Operation
- State is one register, `cnt` (AW+1 bits), plus the `error` register. Status outputs are decoded from `cnt` only, with no request-to-status combinational path.
- A request is decoded each cycle from the `push_req_n`/`pop_req_n` pair:
  - **Push only, not full:** `ram_cs_n=0`, `ram_wr_n=0`, `rw_addr=cnt`. Then `cnt+1`.
  - **Pop only, not empty:** `ram_cs_n=0`, `ram_wr_n=1`, `rw_addr=cnt-1`. Then `cnt-1`.
  - **Idle, not empty:** `ram_cs_n=0`, `ram_wr_n=1`, `rw_addr=cnt-1`. This is a top-of-stack peek.
  - **Idle and empty:** `ram_cs_n=1`, `ram_wr_n=1`, `rw_addr=0`.
- Illegal requests: push when full, pop when empty, or push and pop asserted together.
  - No write: `ram_wr_n=1`.
  - `cnt` unchanged.
  - `ram_cs_n`/`rw_addr` take their idle-case values.
  - `error` is set at the next edge.
- `err_mode=0`: `error` stays set until `rst_n` is low.
- `err_mode=1`: `error` is registered as "this cycle's request was illegal" and clears after one legal or idle cycle.
- Arithmetic: `cnt` never wraps, since both guards are enforced. `cnt-1` is only used when `cnt>0`. `rw_addr` is the truncation of `cnt` or `cnt-1` to AW bits, which is exact because `cnt<depth` on push.

## Timing
- Reset (`rst_n=0` at an edge) overrides any request that cycle:
  - `cnt=0`, so `count=0`, `empty=1`, `almost_empty=1`, `almost_full=0`, `full=0`.
  - `error=0`.
  - Combinational RAM outputs return to the idle-and-empty values (`ram_cs_n=1`, `ram_wr_n=1`, `rw_addr=0`) in the cycle after the edge.
  - A push in progress during a reset cycle is not written.
- RAM controls are combinational from requests and `cnt`, and are valid in the same cycle as the request.
- Push latency: the word is captured by the RAM at the edge ending the request cycle. `count` updates at the same edge.
- Pop latency: data is valid on the RAM `data_out` during the request cycle (asynchronous read), sampled by the consumer at the edge ending it. `count` decrements at that edge.
- Back-to-back push/pop every cycle is supported, giving one operation per cycle.
- Popped slots are not cleared. A push after a pop overwrites the same address.

## Structure
- A shared package `stack_pkg` holds:
  - the `clog2` function used for AW;
  - the `ERR_STICKY=0` and `ERR_DYNAMIC=1` constants.
- A single module with no sub-module. The stack controller and the RAM are connected by the parent.
- Elaboration-time checks reject out-of-range `depth`, `ae_level`, `af_level` and `err_mode`.

## Test plan
All scenarios use `depth=8`, `ae_level=1`, `af_level=1` unless stated.
- **Reset then push ×8** with data 0x10..0x17:
  - `rw_addr` steps 0..7 with `ram_wr_n=0`.
  - `count` goes 1..8; `almost_full` at 7; `full` at 8.
  - `error` stays 0.
- **Full stack, pop ×8:**
  - `rw_addr` steps 7..0 and `data_out` reads 0x17..0x10.
  - `empty=1` after the 8th pop.
  - `almost_empty` at count 1.
- **Push when full (`err_mode=0`):**
  - No `ram_wr_n` low and `count` stays 8.
  - `error=1` next cycle, still 1 after 5 idle cycles, cleared only by `rst_n` low.
- **Pop when empty and simultaneous push+pop (`err_mode=1`):**
  - Each pulses `error` for exactly one cycle.
  - `count` and RAM contents are unchanged.
- **Interleaved traffic:** push 0xA1, push 0xA2, pop, push 0xA3, pop, pop.
  - Data out reads 0xA2, 0xA3, 0xA1.
  - Idle peek shows `rw_addr=cnt-1` between operations.
- **Reset mid-sequence:** `rst_n` low during a push at `count=3`.
  - No write.
  - `count=0`, `empty=1`, `error=0` next cycle.
